dct_coef_deser: RTL

Downstream stage of the 32-point DCT core. Consumes its bit-serial coefficient stream (valid + data pair) and reassembles DW-bit coefficients, MSB first. Tags each coefficient with its in-frame index and a last flag, then buffers it in a first-word-fall-through FIFO behind a valid/ready interface. The FIFO output feeds the wishbone readout / logic-analyzer capture path.

---
 rtl/dct_coef_deser.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dct_coef_deser.sv
// Bit-serial to parallel coefficient deserializer for the 32-point DCT core.
// Words are tagged with their frame index and last flag, then queued in a FWFT FIFO.
module dct_coef_deser #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int IDXW  = 5
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic [2:0]               iSize,
  input  logic                     iSVAL,
  input  logic                     iSDAT,
  output logic [DW-1:0]            oData,
  output logic [IDXW-1:0]          oIdx,
  output logic                     oLast,
  output logic                     oValid,
  input  logic                     iReady,
  output logic [$clog2(DEPTH):0]   oLevel,
  output logic                     oBusy,
  output logic                     oErrTrunc,
  output logic                     oErrOvf
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int BCW = $clog2(DW) + 1;
  localparam int EW  = DW + IDXW + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

  // Frame-size code to index of the final coefficient (N-1); codes 4..7 mean 32.
  function automatic logic [IDXW-1:0] f_nlast(input logic [2:0] code);
    case (code)
      3'd0:    f_nlast = IDXW'(3);
      3'd1:    f_nlast = IDXW'(7);
      3'd2:    f_nlast = IDXW'(15);
      default: f_nlast = IDXW'(31);
    endcase
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DW-2:0]       r_shift;
  logic [BCW-1:0]      r_bitcnt;
  logic [IDXW-1:0]     r_idx;
  logic [IDXW-1:0]     r_nlast;
  logic [EW-1:0]       r_mem [DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [LW-1:0]       r_count;
  logic                r_err_trunc;
  logic                r_err_ovf;

  logic                w_push;
  logic                w_trunc;
  logic                w_last;
  logic [DW-1:0]       w_word;
  logic                w_pop;
  logic                w_full;
  logic                w_wr;
  logic                w_nonempty;
  logic [EW-1:0]       w_head;

  assign w_last = (r_idx == r_nlast);
  assign w_word = {r_shift, iSDAT};

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_trunc     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (iSVAL) begin
          w_state_nxt = S_RECV;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RECV: begin
        if (!iSVAL) begin
          w_trunc     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_bitcnt == BCW'(DW - 1)) begin
          w_push = 1'b1;
          if (w_last) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_RECV;
          end
        end else begin
          w_state_nxt = S_RECV;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift register, bit counter and frame index; iSize is only sampled on the first bit.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_idx    <= '0;
      r_nlast  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iSVAL) begin
            r_nlast  <= f_nlast(iSize);
            r_shift  <= {r_shift[DW-3:0], iSDAT};
            r_bitcnt <= BCW'(1);
            r_idx    <= '0;
          end
        end
        S_RECV: begin
          if (iSVAL) begin
            r_shift <= {r_shift[DW-3:0], iSDAT};
            if (w_push) begin
              r_bitcnt <= '0;
              r_idx    <= r_idx + IDXW'(1);
            end else begin
              r_bitcnt <= r_bitcnt + BCW'(1);
            end
          end else begin
            r_bitcnt <= '0;
          end
        end
        default: r_bitcnt <= '0;
      endcase
    end
  end

  assign w_nonempty = (r_count != '0);
  assign w_pop      = w_nonempty && iReady;
  assign w_full     = (r_count == LW'(DEPTH));
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign w_wr       = w_push && (!w_full || w_pop);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= {w_word, r_idx, w_last};
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_err_trunc <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_err_trunc <= w_trunc;
      r_err_ovf   <= w_push && !w_wr;
    end
  end

  assign w_head    = r_mem[r_rptr];
  assign oValid    = w_nonempty;
  assign oData     = w_nonempty ? w_head[EW-1 -: DW]     : {DW{1'b0}};
  assign oIdx      = w_nonempty ? w_head[IDXW:1]         : {IDXW{1'b0}};
  assign oLast     = w_nonempty ? w_head[0]              : 1'b0;
  assign oLevel    = r_count;
  assign oBusy     = (r_state == S_RECV);
  assign oErrTrunc = r_err_trunc;
  assign oErrOvf   = r_err_ovf;

endmodule
